// File: rtl/regfile_xfer.sv
// Moves a block of words between a 32-entry register file and valid/ready streams.
// LOAD writes a stream into registers. DUMP reads registers out to a stream. Register x0 is never written.
module regfile_xfer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [4:0]       cmd_base,
  input  logic [5:0]       cmd_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             we3,
  output logic [4:0]       a3,
  output logic [WIDTH-1:0] wd3,
  output logic [4:0]       a1,
  input  logic [WIDTH-1:0] rd1,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DUMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [CW-1:0]   remaining;
  logic            armed;
  logic            in_beat;
  logic            dump_load;
  logic            dump_drain;

  // armed keeps cmd_ready low until the first clock edge after reset is released.
  assign cmd_ready  = armed && (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  assign in_ready   = (state == S_LOAD) && (remaining != CW'(0));
  assign in_beat    = in_valid && in_ready;
  assign we3        = in_beat && (ptr != AW'(0));
  assign a3         = in_beat ? ptr : AW'(0);
  assign wd3        = in_beat ? in_data : WIDTH'(0);

  assign a1         = (state == S_DUMP) ? ptr : AW'(0);
  assign dump_load  = (state == S_DUMP) && (!out_valid || out_ready) && (remaining != CW'(0));
  assign dump_drain = (state == S_DUMP) && out_valid && out_ready && (remaining == CW'(0));

  // The controller, the pointer, the word counter and the output word register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= AW'(0);
      remaining <= CW'(0);
      out_valid <= 1'b0;
      out_data  <= WIDTH'(0);
      armed     <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            ptr       <= cmd_base;
            remaining <= cmd_count;
            if (cmd_count == CW'(0)) begin
              state <= S_DONE;
            end else if (cmd_op) begin
              state <= S_DUMP;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (in_beat) begin
            ptr       <= ptr + AW'(1);
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) begin
              state <= S_DONE;
            end
          end
        end
        S_DUMP: begin
          // Refill the output register whenever it is empty or being consumed.
          if (dump_load) begin
            out_data  <= rd1;
            out_valid <= 1'b1;
            ptr       <= ptr + AW'(1);
            remaining <= remaining - CW'(1);
          end else if (dump_drain) begin
            out_valid <= 1'b0;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_xfer.sv
// Bench for regfile_xfer. It uses a behavioural register file plus a reference copy updated from the command semantics.
// It runs directed and randomized LOAD and DUMP commands, including backpressure, wraparound and mid-command reset.
module tb_regfile_xfer;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [4:0]       cmd_base;
  logic [5:0]       cmd_count;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             we3;
  logic [4:0]       a3;
  logic [WIDTH-1:0] wd3;
  logic [4:0]       a1;
  logic [WIDTH-1:0] rd1;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] rf     [32];
  logic [WIDTH-1:0] ref_rf [32];
  int checks = 0;
  int errors = 0;

  regfile_xfer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .we3(we3), .a3(a3), .wd3(wd3), .a1(a1), .rd1(rd1),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment: combinational read, x0 reads as zero.
  assign rd1 = (a1 == 5'd0) ? '0 : rf[a1];
  always @(posedge clk) if (we3) rf[a3] <= wd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [4:0] base, input logic [5:0] cnt);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_count = cnt;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    @(posedge clk);
    #1;
    // cmd_valid stays high with a different base, so the bench can confirm the DUT does not accept it while busy.
    cmd_base = 5'($urandom);
    chk("busy_accepted", busy, 1);
  endtask

  task automatic finish_cmd();
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b0; out_ready = 1'($urandom_range(0, 1));
    #1;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("in_ready_done", in_ready, 0);
    chk("out_valid_done", out_valid, 0);
    chk("we3_done", we3, 0);
    chk("cmd_ready_done", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("done_cleared", done, 0);
    chk("busy_cleared", busy, 0);
    chk("cmd_ready_back", cmd_ready, 1);
  endtask

  // abort_at >= 0 stops after that many beats and leaves the command unfinished.
  task automatic do_load(input logic [4:0] base, input int cnt, input bit hold, input int abort_at);
    int idx = 0;
    int cyc = 0;
    logic [4:0] addr;
    issue(1'b0, base, 6'(cnt));
    while (idx < cnt && idx != abort_at && cyc < 500) begin
      @(negedge clk);
      in_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
      in_data  = $urandom;
      #1;
      addr = 5'(base + 5'(idx));
      chk("in_ready_load", in_ready, 1);
      chk("cmd_ready_load", cmd_ready, 0);
      chk("done_load", done, 0);
      if (in_valid) begin
        chk("we3_beat", we3, {31'd0, addr != 5'd0});
        chk("a3_beat", a3, addr);
        if (addr != 5'd0) begin
          chk("wd3_beat", wd3, in_data);
          ref_rf[addr] = in_data;
        end
        idx++;
      end else begin
        chk("we3_nobeat", we3, 0);
        chk("a3_nobeat", a3, 0);
        chk("wd3_nobeat", wd3, 0);
      end
      cyc++;
    end
    chk("load_beats", idx, (abort_at >= 0) ? abort_at : cnt);
    if (abort_at < 0) finish_cmd();
  endtask

  // mode 0: out_ready always high; 1: pattern 1,0,0 repeating; 2: random.
  task automatic do_dump(input logic [4:0] base, input int cnt, input int mode);
    int got = 0;
    int cyc = 0;
    logic [4:0] addr;
    logic [31:0] exp;
    issue(1'b1, base, 6'(cnt));
    while (got < cnt && cyc < 1000) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      #1;
      chk("we3_dump", we3, 0);
      chk("in_ready_dump", in_ready, 0);
      chk("cmd_ready_dump", cmd_ready, 0);
      chk("done_dump", done, 0);
      chk("a1_dump", a1, 5'(base + 5'(got) + 5'(out_valid)));
      if (mode == 0) chk("out_valid_rate", out_valid, (cyc >= 1) ? 1 : 0);
      if (out_valid) begin
        addr = 5'(base + 5'(got));
        exp  = (addr == 5'd0) ? 32'd0 : ref_rf[addr];
        chk("out_data", out_data, exp);
        if (out_ready) got++;
      end
      cyc++;
    end
    chk("dump_words", got, cnt);
    finish_cmd();
  endtask

  initial begin
    logic [4:0] b;
    int cnt;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_count = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rf[i] = (i == 0) ? 32'd0 : $urandom;
      ref_rf[i] = rf[i];
    end

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_we3", we3, 0);
    chk("rst_a1", a1, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("cmd_ready_at_release", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("cmd_ready_after_release", cmd_ready, 1);

    do_load(5'd3, 4, 1'b1, -1);
    do_dump(5'd3, 4, 0);
    do_load(5'd30, 4, 1'b1, -1);
    do_dump(5'd31, 3, 0);
    do_dump(5'd3, 5, 1);
    do_load(5'd7, 0, 1'b1, -1);
    do_dump(5'd9, 0, 0);
    do_load(5'd0, 32, 1'b0, -1);
    do_dump(5'd0, 32, 0);

    // Abort a LOAD after two beats. The remaining registers must keep their old contents.
    do_load(5'd8, 6, 1'b1, 2);
    @(negedge clk);
    in_valid = 1'b1; in_data = $urandom; reset = 1'b1;
    #1;
    chk("abort_we3", we3, 0);
    chk("abort_a3", a3, 0);
    chk("abort_wd3", wd3, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    chk("abort_a1", a1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("abort_we3_held", we3, 0);
    reset = 1'b0; cmd_valid = 1'b0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    do_dump(5'd8, 6, 2);

    for (int n = 0; n < 20; n++) begin
      b   = 5'($urandom);
      cnt = $urandom_range(0, 32);
      if ($urandom_range(0, 1) == 0) do_load(b, cnt, 1'($urandom_range(0, 1)), -1);
      else                           do_dump(b, cnt, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
